// File: rtl/onehot_sel_seq_if.sv
// Command/beat bundle for the one-hot select sequencer.
// master = control/test sequencer side, slave = the sequencer block.
interface onehot_sel_seq_if #(
  parameter int SEL_W = 2
);
  localparam int N_OUT = 2**SEL_W;

  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] sel;
  logic             sweep;
  logic             dir;
  logic             abort;
  logic [N_OUT-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic             busy;

  modport master (
    output in_valid,
    input  in_ready,
    output sel,
    output sweep,
    output dir,
    output abort,
    input  y,
    input  out_valid,
    output out_ready,
    input  out_last,
    input  busy
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  sel,
    input  sweep,
    input  dir,
    input  abort,
    output y,
    output out_valid,
    input  out_ready,
    output out_last,
    output busy
  );
endinterface

// File: rtl/onehot_sel_seq.sv
// Registered select-to-one-hot decoder with direct and sweep
// commands behind valid/ready handshakes.
module onehot_sel_seq #(
  parameter int SEL_W     = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic          clk,
  input logic          rst,
  onehot_sel_seq_if.slave bus
);
  localparam int N_OUT = 2**SEL_W;
  localparam logic [SEL_W-1:0] ONE = SEL_W'(1);
  localparam logic [SEL_W-1:0] BL_INIT = SEL_W'(N_OUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SWEEP
  } state_t;

  state_t state_q, state_d;

  logic [N_OUT-1:0] y_q, y_d;
  logic             vld_q, vld_d;
  logic             last_q, last_d;
  logic             dir_q, dir_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [SEL_W-1:0] bl_q, bl_d;
  logic [SEL_W-1:0] idx_nxt;
  logic [SEL_W-1:0] bl_nxt;
  logic             accept;
  logic             hs;
  logic             abort_sw;

  function automatic logic [N_OUT-1:0] onehot(
    input logic [SEL_W-1:0] k
  );
    logic [N_OUT-1:0] v;
    v = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (MSB_FIRST)
        v[i] = ((N_OUT - 1 - i) == int'(k));
      else
        v[i] = (i == int'(k));
    end
    return v;
  endfunction

  assign bus.in_ready =
    (~vld_q | (bus.out_ready & last_q)) & ~rst;

  assign accept   = bus.in_valid & bus.in_ready;
  assign hs       = vld_q & bus.out_ready;
  assign abort_sw = bus.abort & (state_q == SWEEP);

  assign idx_nxt = dir_q ? idx_q - ONE : idx_q + ONE;
  assign bl_nxt  = bl_q - ONE;

  // accept can only fire on the final beat, so it never
  // competes with an abort of a non-last sweep beat
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vld_d   = vld_q;
    last_d  = last_q;
    dir_d   = dir_q;
    idx_d   = idx_q;
    bl_d    = bl_q;
    if (accept) begin
      y_d   = onehot(bus.sel);
      vld_d = 1'b1;
      if (bus.sweep) begin
        idx_d   = bus.sel;
        bl_d    = BL_INIT;
        dir_d   = bus.dir;
        last_d  = (N_OUT == 1);
        state_d = SWEEP;
      end else begin
        last_d  = 1'b1;
        state_d = DIRECT;
      end
    end else if (abort_sw) begin
      vld_d   = 1'b0;
      last_d  = 1'b0;
      state_d = IDLE;
    end else if (hs) begin
      if (last_q) begin
        vld_d   = 1'b0;
        last_d  = 1'b0;
        state_d = IDLE;
      end else begin
        idx_d  = idx_nxt;
        bl_d   = bl_nxt;
        y_d    = onehot(idx_nxt);
        last_d = (bl_nxt == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      dir_q   <= 1'b0;
      idx_q   <= '0;
      bl_q    <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      dir_q   <= dir_d;
      idx_q   <= idx_d;
      bl_q    <= bl_d;
    end
  end

  assign bus.y         = y_q;
  assign bus.out_valid = vld_q;
  assign bus.out_last  = last_q;
  assign bus.busy      = (state_q == SWEEP);
endmodule

// File: tb/tb_onehot_sel_seq.sv
// Scoreboard bench for onehot_sel_seq: 2-bit MSB-first
// instance plus a 3-bit LSB-first instance.
module tb_onehot_sel_seq;
  logic clk;
  logic rst;

  onehot_sel_seq_if #(.SEL_W(2)) b ();
  onehot_sel_seq_if #(.SEL_W(3)) c ();

  onehot_sel_seq #(.SEL_W(2), .MSB_FIRST(1'b1)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  onehot_sel_seq #(.SEL_W(3), .MSB_FIRST(1'b0)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (c.slave)
  );

  typedef struct {
    logic [3:0] y;
    logic       last;
  } beat_t;

  beat_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_oh(input int w,
                                        input bit msb,
                                        input int k);
    int n;
    n = 1 << w;
    return msb ? (8'd1 << (n - 1 - k)) : (8'd1 << k);
  endfunction

  always @(negedge clk) begin
    beat_t e;
    if (!rst && b.out_valid && b.out_ready &&
        !(b.abort && b.busy)) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_y", 32'(b.y), 32'(e.y));
        chk("sb_last", 32'(b.out_last), 32'(e.last));
      end
    end
  end

  task automatic push_beats(input int s, input bit sw,
                            input bit d);
    beat_t      e;
    logic [7:0] t;
    int         idx;
    if (!sw) begin
      t = exp_oh(2, 1'b1, s);
      e.y = t[3:0];
      e.last = 1'b1;
      sb.push_back(e);
    end else begin
      for (int i = 0; i < 4; i++) begin
        idx = d ? ((s - i) & 3) : ((s + i) & 3);
        t = exp_oh(2, 1'b1, idx);
        e.y = t[3:0];
        e.last = (i == 3);
        sb.push_back(e);
      end
    end
  endtask

  task automatic cmd(input int s, input bit sw, input bit d);
    int k;
    b.in_valid = 1'b1;
    b.sel      = 2'(s);
    b.sweep    = sw;
    b.dir      = d;
    k = 0;
    @(negedge clk);
    while (!b.in_ready && k < 50) begin
      k++;
      @(negedge clk);
    end
    if (!b.in_ready) chk("cmd_timeout", 32'd0, 32'd1);
    push_beats(s, sw, d);
    @(posedge clk);
    #1;
    b.in_valid = 1'b0;
    b.sweep    = 1'b0;
    b.dir      = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || b.out_valid) && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("drain_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    b.in_valid = 0; b.sel = 0; b.sweep = 0; b.dir = 0;
    b.abort = 0; b.out_ready = 1;
    c.in_valid = 0; c.sel = 0; c.sweep = 0; c.dir = 0;
    c.abort = 0; c.out_ready = 1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_y", 32'(b.y), 32'd0);
    chk("rst_valid", 32'(b.out_valid), 32'd0);
    chk("rst_last", 32'(b.out_last), 32'd0);
    chk("rst_busy", 32'(b.busy), 32'd0);
    chk("rst_in_ready", 32'(b.in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(b.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // direct sel=2
    cmd(2, 1'b0, 1'b0);
    @(negedge clk);
    chk("dir_valid", 32'(b.out_valid), 32'd1);
    @(negedge clk);
    chk("dir_idle", 32'(b.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // sweep up from 3
    cmd(3, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("sw_busy", 32'(b.busy), 32'd1);
      chk("sw_in_ready", 32'(b.in_ready), 32'(i == 3));
    end
    @(negedge clk);
    chk("sw_busy_end", 32'(b.busy), 32'd0);
    chk("sw_valid_end", 32'(b.out_valid), 32'd0);
    @(posedge clk);
    #1;

    // sweep down from 0 with a stall on beat 2
    cmd(0, 1'b1, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #1 b.out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_y", 32'(b.y), 32'h1);
    end
    @(posedge clk);
    #1 b.out_ready = 1'b1;
    drain();

    // abort on beat 2
    cmd(1, 1'b1, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1 b.abort = 1'b1;
    @(posedge clk);
    #1 b.abort = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_valid", 32'(b.out_valid), 32'd0);
    chk("abort_busy", 32'(b.busy), 32'd0);
    chk("abort_in_ready", 32'(b.in_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd(0, 1'b0, 1'b0);
    drain();

    // back-to-back direct then sweep
    cmd(1, 1'b0, 1'b0);
    cmd(2, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b2b_valid", 32'(b.out_valid), 32'd1);
    end
    drain();

    // reset on sweep beat 3
    cmd(0, 1'b1, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_y", 32'(b.y), 32'd0);
    chk("mid_rst_valid", 32'(b.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(b.busy), 32'd0);
    chk("mid_rst_in_ready", 32'(b.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // 3-bit LSB-first instance
    c.in_valid = 1'b1;
    c.sel = 3'd5;
    @(negedge clk);
    chk("w3_in_ready", 32'(c.in_ready), 32'd1);
    @(posedge clk);
    #1 c.in_valid = 1'b0;
    @(negedge clk);
    chk("w3_dir_y", 32'(c.y), 32'h20);
    chk("w3_dir_last", 32'(c.out_last), 32'd1);
    @(posedge clk);
    #1;
    c.in_valid = 1'b1;
    c.sel = 3'd6;
    c.sweep = 1'b1;
    @(posedge clk);
    #1;
    c.in_valid = 1'b0;
    c.sweep = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("w3_sw_y", 32'(c.y), 32'(exp_oh(3, 1'b0, (6 + i) & 7)));
      chk("w3_sw_last", 32'(c.out_last), 32'(i == 7));
    end
    @(negedge clk);
    chk("w3_busy_end", 32'(c.busy), 32'd0);

    chk("sb_leftover", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
